avr_tx_arbiter: RTL and testbench

Shares the single AVR serial transmit byte channel (tx_data / new_tx_data / tx_busy of avr_interface) among NUM_REQ packet sources, e.g. debug telemetry, flag status and control logging. Arbitration is packet-level round-robin: a granted requester keeps the channel until its last byte or a stall timeout. The block sits between the sources and avr_interface in the avionics top level.

---
 rtl/avr_tx_arbiter_if.sv | 23 ++
 rtl/avr_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_avr_tx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avr_tx_arbiter_if.sv
// Byte-stream bundle between the packet sources, the transmit arbiter and avr_interface.
// The slave side is the arbiter; the master side is the surrounding top level.
interface avr_tx_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 new_tx_data;
   logic                 tx_busy;

   modport master (
      output req_data, req_valid, req_last, tx_busy,
      input  req_ready, tx_data, new_tx_data
   );

   modport slave (
      input  req_data, req_valid, req_last, tx_busy,
      output req_ready, tx_data, new_tx_data
   );
endinterface

// File: rtl/avr_tx_arbiter.sv
// Packet-level round-robin arbiter for the AVR serial transmit byte channel.
// An owner keeps the channel until its last byte drains or it stalls for TIMEOUT cycles.
module avr_tx_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ID_BITS    = 2,
   parameter int unsigned BUSY_GUARD = 2,
   parameter int unsigned TIMEOUT    = 50000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   avr_tx_arbiter_if.slave    bus,
   output logic [NUM_REQ-1:0] grant,
   output logic               busy,
   output logic               abort,
   output logic [ID_BITS-1:0] abort_id
);
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned GRD_W = 4;

   typedef enum logic [1:0] {ARB, SEND, GUARD, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [ID_BITS-1:0] rr_q, rr_d;
   logic [ID_BITS-1:0] own_q, own_d;
   logic [ID_BITS-1:0] abort_id_d;
   logic [NUM_REQ-1:0] grant_d;
   logic               busy_d;
   logic               abort_d;
   logic               new_tx_d;
   logic               last_q, last_d;
   logic [7:0]         tx_data_d;
   logic [CNT_W-1:0]   stall_q, stall_d;
   logic [GRD_W-1:0]   guard_q, guard_d;

   logic [7:0]         req_byte [NUM_REQ];
   logic               win_found;
   logic [ID_BITS-1:0] win_id;
   logic [ID_BITS-1:0] scan_id;
   logic [ID_BITS-1:0] rr_next;
   logic               accept;
   logic               stalled;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_byte[i] = bus.req_data[8*i +: 8];
   end

   assign rr_next = (own_q == ID_BITS'(NUM_REQ - 1)) ? '0 : ID_BITS'(own_q + 1'b1);
   assign accept  = (state_q == SEND) && !bus.tx_busy && bus.req_valid[own_q];
   assign stalled = (state_q == SEND) && !bus.tx_busy && !bus.req_valid[own_q];

   assign bus.req_ready = ((state_q == SEND) && !bus.tx_busy) ? grant : '0;

   // First valid requester scanning upward from the round-robin pointer.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_id   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_id = ID_BITS'((32'(rr_q) + k) % NUM_REQ);
         if (!win_found && bus.req_valid[scan_id]) begin
            win_found = 1'b1;
            win_id    = scan_id;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      own_d      = own_q;
      grant_d    = grant;
      busy_d     = busy;
      tx_data_d  = bus.tx_data;
      new_tx_d   = 1'b0;
      last_d     = last_q;
      abort_d    = 1'b0;
      abort_id_d = abort_id;
      stall_d    = stall_q;
      guard_d    = guard_q;

      case (state_q)
         ARB: begin
            stall_d = '0;
            if (en && win_found) begin
               own_d   = win_id;
               grant_d = NUM_REQ'(1) << win_id;
               busy_d  = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (accept) begin
               tx_data_d = req_byte[own_q];
               last_d    = bus.req_last[own_q];
               new_tx_d  = 1'b1;
               stall_d   = '0;
               guard_d   = '0;
               state_d   = GUARD;
            end else if (stalled && (TIMEOUT != 0)) begin
               // Stalled owner: release the channel once the budget is used up.
               if (stall_q == CNT_W'(TIMEOUT - 1)) begin
                  abort_d    = 1'b1;
                  abort_id_d = own_q;
                  grant_d    = '0;
                  busy_d     = 1'b0;
                  rr_d       = rr_next;
                  stall_d    = '0;
                  state_d    = ARB;
               end else begin
                  stall_d = stall_q + 1'b1;
               end
            end
         end
         GUARD: begin
            if (guard_q == GRD_W'(BUSY_GUARD - 1)) begin
               state_d = DRAIN;
            end else begin
               guard_d = guard_q + 1'b1;
            end
         end
         DRAIN: begin
            if (!bus.tx_busy) begin
               if (last_q) begin
                  grant_d = '0;
                  busy_d  = 1'b0;
                  rr_d    = rr_next;
                  state_d = ARB;
               end else begin
                  state_d = SEND;
               end
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ARB;
         rr_q            <= '0;
         own_q           <= '0;
         grant           <= '0;
         busy            <= 1'b0;
         bus.tx_data     <= '0;
         bus.new_tx_data <= 1'b0;
         last_q          <= 1'b0;
         abort           <= 1'b0;
         abort_id        <= '0;
         stall_q         <= '0;
         guard_q         <= '0;
      end else begin
         state_q         <= state_d;
         rr_q            <= rr_d;
         own_q           <= own_d;
         grant           <= grant_d;
         busy            <= busy_d;
         bus.tx_data     <= tx_data_d;
         bus.new_tx_data <= new_tx_d;
         last_q          <= last_d;
         abort           <= abort_d;
         abort_id        <= abort_id_d;
         stall_q         <= stall_d;
         guard_q         <= guard_d;
      end
   end
endmodule

// File: tb/tb_avr_tx_arbiter.sv
// Directed bench for avr_tx_arbiter: queued packet sources, a busy-stretching
// transmitter model and a log of every new_tx_data strobe checked against hand-written vectors.
module tb_avr_tx_arbiter;
   localparam int unsigned NR = 4;

   logic          clk;
   logic          rst;
   logic          en;
   logic [NR-1:0] grant;
   logic          busy;
   logic          abort;
   logic [1:0]    abort_id;

   avr_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

   avr_tx_arbiter #(
      .NUM_REQ(NR), .ID_BITS(2), .BUSY_GUARD(2), .TIMEOUT(20)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .bus(bus),
      .grant(grant), .busy(busy), .abort(abort), .abort_id(abort_id)
   );

   int            n_chk = 0;
   int            n_bad = 0;
   int            cyc = 0;
   int            bcnt = 0;
   int            busy_len = 5;
   int            strobe_cnt = 0;
   int            abort_cnt = 0;
   int            abort_cyc = 0;
   int            fall_cyc = 0;
   int            viol = 0;
   int            n0;
   int            a0;
   logic [NR-1:0] acc = '0;
   logic [8:0]    src_q [NR][$];
   logic [7:0]    log_data [$];
   logic [NR-1:0] log_grant [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int id, input logic [7:0] d, input logic last);
      src_q[id].push_back({last, d});
   endtask

   function automatic logic q_empty();
      logic e;
      e = 1'b1;
      for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   // One clock: observe after the edge, then drive sources and tx_busy on the falling edge.
   task automatic step();
      logic [31:0]   d;
      logic [NR-1:0] v;
      logic [NR-1:0] l;
      logic [8:0]    w;
      logic          prev;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NR; i++)
         if (((acc >> i) & NR'(1)) != '0 && src_q[i].size() != 0) w = src_q[i].pop_front();
      if (bus.new_tx_data) begin
         log_data.push_back(bus.tx_data);
         log_grant.push_back(grant);
         strobe_cnt++;
         bcnt = busy_len;
      end
      if (abort) begin
         abort_cnt++;
         abort_cyc = cyc;
      end
      @(negedge clk);
      prev = bus.tx_busy;
      bus.tx_busy = (bcnt != 0);
      if (bcnt != 0) bcnt--;
      if (prev && !bus.tx_busy) fall_cyc = cyc;
      d = '0;
      v = '0;
      l = '0;
      for (int i = 0; i < NR; i++) begin
         if (src_q[i].size() != 0) begin
            w = src_q[i][0];
            v = v | (NR'(1) << i);
            l = l | (NR'(w[8]) << i);
            d = d | (32'(w[7:0]) << (8*i));
         end
      end
      bus.req_data  = d;
      bus.req_valid = v;
      bus.req_last  = l;
      #1;
      acc = bus.req_valid & bus.req_ready;
      if (bus.tx_busy && (bus.req_ready != '0)) viol++;
      if ((bus.req_ready & ~grant) != '0) viol++;
   endtask

   task automatic wait_strobe(input string tag, input int n, input int max);
      int i;
      i = 0;
      while (strobe_cnt == n && i < max) begin
         step();
         i++;
      end
      chk({tag, "_strobe"}, 32'(strobe_cnt > n), 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int max);
      int   i;
      logic done;
      i = 0;
      done = 1'b0;
      while (!done && i < max) begin
         step();
         i++;
         done = !busy && (bcnt == 0) && !bus.tx_busy && q_empty();
      end
      chk({tag, "_idle"}, 32'(done), 32'd1);
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] d, input logic [NR-1:0] g);
      logic [7:0]    got_d;
      logic [NR-1:0] got_g;
      chk({tag, "_avail"}, 32'(log_data.size() != 0), 32'd1);
      if (log_data.size() != 0) begin
         got_d = log_data.pop_front();
         got_g = log_grant.pop_front();
         chk({tag, "_data"}, 32'(got_d), 32'(d));
         chk({tag, "_grant"}, 32'(got_g), 32'(g));
      end
   endtask

   initial begin
      rst = 1'b0;
      en  = 1'b1;
      bus.req_data  = '0;
      bus.req_valid = '0;
      bus.req_last  = '0;
      bus.tx_busy   = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("rst_new_tx", 32'(bus.new_tx_data), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      chk("rst_abort_id", 32'(abort_id), 32'd0);
      repeat (2) step();
      rst = 1'b0;

      // Single source, three-byte packet.
      push(1, 8'hA1, 1'b0);
      push(1, 8'hA2, 1'b0);
      push(1, 8'hA3, 1'b1);
      wait_idle("t1", 300);
      expect_byte("t1_b0", 8'hA1, 4'b0010);
      expect_byte("t1_b1", 8'hA2, 4'b0010);
      expect_byte("t1_b2", 8'hA3, 4'b0010);
      chk("t1_grant_end", 32'(grant), 32'd0);
      chk("t1_busy_end", 32'(busy), 32'd0);
      // Pointer now 2: req 3 must beat req 1.
      push(1, 8'hB1, 1'b1);
      push(3, 8'hC1, 1'b1);
      wait_idle("t1r", 300);
      expect_byte("t1r_first", 8'hC1, 4'b1000);
      expect_byte("t1r_second", 8'hB1, 4'b0010);

      // Contention from reset.
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      push(0, 8'hD0, 1'b0);
      push(0, 8'hD1, 1'b1);
      push(2, 8'hE0, 1'b1);
      wait_idle("t2", 300);
      expect_byte("t2_d0", 8'hD0, 4'b0001);
      expect_byte("t2_d1", 8'hD1, 4'b0001);
      expect_byte("t2_e0", 8'hE0, 4'b0100);
      push(0, 8'hF0, 1'b1);
      push(2, 8'hC0, 1'b1);
      wait_idle("t2b", 300);
      expect_byte("t2b_f0", 8'hF0, 4'b0001);
      expect_byte("t2b_c0", 8'hC0, 4'b0100);

      // Back-pressure: 100-cycle busy after the first byte.
      n0 = strobe_cnt;
      a0 = abort_cnt;
      busy_len = 100;
      push(2, 8'h90, 1'b0);
      push(2, 8'h91, 1'b1);
      wait_strobe("t3", n0, 50);
      busy_len = 5;
      repeat (100) step();
      chk("t3_no_strobe", 32'(strobe_cnt), 32'(n0 + 1));
      chk("t3_no_abort", 32'(abort_cnt), 32'(a0));
      wait_idle("t3", 300);
      expect_byte("t3_b0", 8'h90, 4'b0100);
      expect_byte("t3_b1", 8'h91, 4'b0100);

      // Timeout: req 3 sends one byte without last and goes quiet.
      n0 = strobe_cnt;
      a0 = abort_cnt;
      push(3, 8'h3A, 1'b0);
      wait_strobe("t4", n0, 50);
      push(1, 8'h1B, 1'b1);
      for (int i = 0; i < 100 && abort_cnt == a0; i++) step();
      chk("t4_abort_seen", 32'(abort_cnt), 32'(a0 + 1));
      chk("t4_abort_delay", 32'(abort_cyc - fall_cyc), 32'd21);
      chk("t4_abort_id", 32'(abort_id), 32'd3);
      chk("t4_grant_clr", 32'(grant), 32'd0);
      chk("t4_busy_clr", 32'(busy), 32'd0);
      step();
      chk("t4_abort_pulse", 32'(abort), 32'd0);
      wait_idle("t4", 300);
      expect_byte("t4_b0", 8'h3A, 4'b1000);
      expect_byte("t4_next", 8'h1B, 4'b0010);
      chk("t4_abort_once", 32'(abort_cnt), 32'(a0 + 1));

      // en low in ARB blocks grants.
      en = 1'b0;
      n0 = strobe_cnt;
      push(1, 8'h51, 1'b1);
      repeat (10) step();
      chk("t5_no_grant", 32'(grant), 32'd0);
      chk("t5_no_strobe", 32'(strobe_cnt), 32'(n0));
      en = 1'b1;
      wait_idle("t5", 300);
      expect_byte("t5_b0", 8'h51, 4'b0010);
      // en falling mid-packet lets the packet finish, then blocks.
      n0 = strobe_cnt;
      push(3, 8'h60, 1'b0);
      push(3, 8'h61, 1'b0);
      push(3, 8'h62, 1'b1);
      push(0, 8'h70, 1'b1);
      wait_strobe("t5m", n0, 50);
      en = 1'b0;
      for (int i = 0; i < 300 && busy; i++) step();
      repeat (10) step();
      chk("t5m_grant", 32'(grant), 32'd0);
      chk("t5m_pending", 32'(src_q[0].size()), 32'd1);
      expect_byte("t5m_b0", 8'h60, 4'b1000);
      expect_byte("t5m_b1", 8'h61, 4'b1000);
      expect_byte("t5m_b2", 8'h62, 4'b1000);
      chk("t5m_nothing_else", 32'(log_data.size()), 32'd0);
      en = 1'b1;
      wait_idle("t5m", 300);
      expect_byte("t5m_late", 8'h70, 4'b0001);

      // Asynchronous reset while the first byte is in GUARD.
      n0 = strobe_cnt;
      push(2, 8'hE5, 1'b0);
      push(2, 8'hE6, 1'b1);
      wait_strobe("t6", n0, 50);
      rst = 1'b1;
      #1;
      chk("t6_new_tx", 32'(bus.new_tx_data), 32'd0);
      chk("t6_grant", 32'(grant), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      for (int i = 0; i < NR; i++) src_q[i].delete();
      acc = '0;
      bcnt = 0;
      bus.tx_busy = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      expect_byte("t6_pre", 8'hE5, 4'b0100);
      push(0, 8'h0A, 1'b1);
      push(3, 8'h3B, 1'b1);
      wait_idle("t6", 300);
      expect_byte("t6_first", 8'h0A, 4'b0001);
      expect_byte("t6_second", 8'h3B, 4'b1000);

      chk("handshake_rules", 32'(viol), 32'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
